// File: rtl/uart_fifo_cfg.sv
// uart_fifo_cfg: buffered full-duplex UART with show-ahead RX/TX FIFOs, fill counts and sticky errors.
// Optional macro UART_LOOPBACK_EN adds iLoopback, which feeds the TX line into the RX path and parks oTx high.
module uart_fifo_cfg #(
    parameter int unsigned pClkFreq     = 48_000_000,
    parameter int unsigned pBaudRate    = 115200,
    parameter int unsigned pDataBits    = 8,
    parameter int unsigned pParity      = 0,
    parameter int unsigned pStopBits    = 1,
    parameter int unsigned pRxFifoDepth = 16,
    parameter int unsigned pTxFifoDepth = 16
) (
    input  logic                            iClk,
    input  logic                            iResetn,
    input  logic                            iRx,
`ifdef UART_LOOPBACK_EN
    input  logic                            iLoopback,
`endif
    output logic                            oTx,
    output logic [pDataBits-1:0]            oRxData,
    input  logic                            iRxRead,
    output logic                            oRxEmpty,
    output logic [$clog2(pRxFifoDepth):0]   oRxCount,
    input  logic [pDataBits-1:0]            iTxData,
    input  logic                            iTxWrite,
    output logic                            oTxFull,
    output logic [$clog2(pTxFifoDepth):0]   oTxCount,
    output logic                            oTxBusy,
    output logic [2:0]                      oErrFlags,
    input  logic                            iErrClear
);

    localparam int unsigned BIT      = pClkFreq / pBaudRate;
    localparam int unsigned HALF     = BIT / 2;
    localparam int unsigned STOP_LEN = BIT * pStopBits;
    localparam int unsigned TW       = $clog2(STOP_LEN + 1);
    localparam int unsigned DBW      = $clog2(pDataBits);
    localparam int unsigned RAW      = $clog2(pRxFifoDepth);
    localparam int unsigned TAW      = $clog2(pTxFifoDepth);
    localparam int unsigned RCW      = RAW + 1;
    localparam int unsigned TCW      = TAW + 1;

    localparam logic [TW-1:0]  BIT_LAST  = TW'(BIT - 1);
    localparam logic [TW-1:0]  HALF_LAST = TW'(HALF - 1);
    localparam logic [TW-1:0]  STOP_LAST = TW'(STOP_LEN - 1);
    localparam logic [DBW-1:0] DATA_LAST = DBW'(pDataBits - 1);
    localparam logic           ODD       = (pParity == 1);
    localparam logic           PAR_EN    = (pParity != 0);

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;
    localparam logic [2:0] RX_BREAK  = 3'd5;

    // ---------------------------------------------------------------- TX FIFO
    logic [pDataBits-1:0] txMem [pTxFifoDepth];
    logic [TAW-1:0]       txWrPtr, txRdPtr;
    logic [TCW-1:0]       txCountNext;
    logic [pDataBits-1:0] txHead;
    logic                 txPush, txPop, txEmpty;

    assign txEmpty     = (oTxCount == '0);
    assign txHead      = txMem[txRdPtr];
    assign txPush      = iTxWrite && !oTxFull;
    assign txCountNext = oTxCount + TCW'(txPush) - TCW'(txPop);

    always_ff @(posedge iClk) begin
        if (txPush) txMem[txWrPtr] <= iTxData;
    end

    // ---------------------------------------------------------------- TX engine
    logic [2:0]           txState, txStateNext;
    logic [TW-1:0]        txTimer, txTimerNext;
    logic [DBW-1:0]       txBit, txBitNext;
    logic [pDataBits-1:0] txShift, txShiftNext;
    logic                 txPar, txParNext;
    logic                 txLine, txLineNext, txOutNext;

    always_comb begin
        txStateNext = txState;
        txTimerNext = txTimer;
        txBitNext   = txBit;
        txShiftNext = txShift;
        txParNext   = txPar;
        txLineNext  = txLine;
        txPop       = 1'b0;
        case (txState)
            TX_IDLE: begin
                txLineNext = 1'b1;
                if (!txEmpty) begin
                    txPop       = 1'b1;
                    txShiftNext = txHead;
                    txParNext   = (^txHead) ^ ODD;
                    txTimerNext = '0;
                    txLineNext  = 1'b0;
                    txStateNext = TX_START;
                end
            end
            TX_START: begin
                txTimerNext = txTimer + TW'(1);
                if (txTimer == BIT_LAST) begin
                    txTimerNext = '0;
                    txBitNext   = '0;
                    txLineNext  = txShift[0];
                    txStateNext = TX_DATA;
                end
            end
            TX_DATA: begin
                txTimerNext = txTimer + TW'(1);
                if (txTimer == BIT_LAST) begin
                    txTimerNext = '0;
                    if (txBit == DATA_LAST) begin
                        txLineNext  = PAR_EN ? txPar : 1'b1;
                        txStateNext = PAR_EN ? TX_PARITY : TX_STOP;
                    end else begin
                        txBitNext   = txBit + DBW'(1);
                        txShiftNext = txShift >> 1;
                        txLineNext  = txShift[1];
                    end
                end
            end
            TX_PARITY: begin
                txTimerNext = txTimer + TW'(1);
                if (txTimer == BIT_LAST) begin
                    txTimerNext = '0;
                    txLineNext  = 1'b1;
                    txStateNext = TX_STOP;
                end
            end
            TX_STOP: begin
                txTimerNext = txTimer + TW'(1);
                if (txTimer == STOP_LAST) begin
                    txTimerNext = '0;
                    // Chain straight into the next start bit so queued frames leave no idle gap.
                    if (!txEmpty) begin
                        txPop       = 1'b1;
                        txShiftNext = txHead;
                        txParNext   = (^txHead) ^ ODD;
                        txLineNext  = 1'b0;
                        txStateNext = TX_START;
                    end else begin
                        txLineNext  = 1'b1;
                        txStateNext = TX_IDLE;
                    end
                end
            end
            default: begin
                txLineNext  = 1'b1;
                txStateNext = TX_IDLE;
            end
        endcase
    end

`ifdef UART_LOOPBACK_EN
    assign txOutNext = iLoopback ? 1'b1 : txLineNext;
`else
    assign txOutNext = txLineNext;
`endif

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            txState  <= TX_IDLE;
            txTimer  <= '0;
            txBit    <= '0;
            txShift  <= '0;
            txPar    <= 1'b0;
            txLine   <= 1'b1;
            oTx      <= 1'b1;
            txWrPtr  <= '0;
            txRdPtr  <= '0;
            oTxCount <= '0;
            oTxFull  <= 1'b0;
            oTxBusy  <= 1'b0;
        end else begin
            txState  <= txStateNext;
            txTimer  <= txTimerNext;
            txBit    <= txBitNext;
            txShift  <= txShiftNext;
            txPar    <= txParNext;
            txLine   <= txLineNext;
            oTx      <= txOutNext;
            txWrPtr  <= txWrPtr + TAW'(txPush);
            txRdPtr  <= txRdPtr + TAW'(txPop);
            oTxCount <= txCountNext;
            oTxFull  <= (txCountNext == TCW'(pTxFifoDepth));
            oTxBusy  <= (txCountNext != '0) || (txStateNext != TX_IDLE);
        end
    end

    // ---------------------------------------------------------------- RX synchroniser
    logic rxIn, rxMeta, rxSync, rxPrev;

`ifdef UART_LOOPBACK_EN
    assign rxIn = iLoopback ? txLine : iRx;
`else
    assign rxIn = iRx;
`endif

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rxIn;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    // ---------------------------------------------------------------- RX engine
    logic [2:0]           rxState, rxStateNext;
    logic [TW-1:0]        rxTimer, rxTimerNext;
    logic [DBW-1:0]       rxBit, rxBitNext;
    logic [pDataBits-1:0] rxShift, rxShiftNext;
    logic                 rxParErr, rxParErrNext;
    logic                 rxPushReq, setPar, setFrm;

    always_comb begin
        rxStateNext  = rxState;
        rxTimerNext  = rxTimer;
        rxBitNext    = rxBit;
        rxShiftNext  = rxShift;
        rxParErrNext = rxParErr;
        rxPushReq    = 1'b0;
        setPar       = 1'b0;
        setFrm       = 1'b0;
        case (rxState)
            RX_IDLE: begin
                if (rxPrev && !rxSync) begin
                    rxTimerNext  = '0;
                    rxParErrNext = 1'b0;
                    rxStateNext  = RX_START;
                end
            end
            RX_START: begin
                rxTimerNext = rxTimer + TW'(1);
                if (rxTimer == HALF_LAST) begin
                    rxTimerNext = '0;
                    rxBitNext   = '0;
                    rxStateNext = rxSync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                rxTimerNext = rxTimer + TW'(1);
                if (rxTimer == BIT_LAST) begin
                    rxTimerNext = '0;
                    rxShiftNext = {rxSync, rxShift[pDataBits-1:1]};
                    if (rxBit == DATA_LAST) begin
                        rxStateNext = PAR_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rxBitNext = rxBit + DBW'(1);
                    end
                end
            end
            RX_PARITY: begin
                rxTimerNext = rxTimer + TW'(1);
                if (rxTimer == BIT_LAST) begin
                    rxTimerNext  = '0;
                    rxParErrNext = (rxSync != ((^rxShift) ^ ODD));
                    rxStateNext  = RX_STOP;
                end
            end
            RX_STOP: begin
                rxTimerNext = rxTimer + TW'(1);
                if (rxTimer == BIT_LAST) begin
                    rxTimerNext = '0;
                    if (rxSync) begin
                        rxPushReq   = 1'b1;
                        setPar      = PAR_EN && rxParErr;
                        rxStateNext = RX_IDLE;
                    end else begin
                        setFrm      = 1'b1;
                        rxStateNext = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rxSync) rxStateNext = RX_IDLE;
            end
            default: rxStateNext = RX_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- RX FIFO
    logic [pDataBits-1:0] rxMem [pRxFifoDepth];
    logic [RAW-1:0]       rxWrPtr, rxRdPtr, rxRdPtrNext;
    logic [RCW-1:0]       rxCountNext;
    logic [pDataBits-1:0] rxHeadNext;
    logic                 rxFull, rxPush, rxPop, setOvr;

    assign rxFull      = (oRxCount == RCW'(pRxFifoDepth));
    assign rxPush      = rxPushReq && !rxFull;
    assign setOvr      = rxPushReq && rxFull;
    assign rxPop       = iRxRead && !oRxEmpty;
    assign rxCountNext = oRxCount + RCW'(rxPush) - RCW'(rxPop);
    assign rxRdPtrNext = rxRdPtr + RAW'(rxPop);

    // Registered head: the word being written this edge becomes head when nothing older remains.
    always_comb begin
        rxHeadNext = oRxData;
        if (rxCountNext != '0) begin
            if (rxPush && (rxRdPtrNext == rxWrPtr)) rxHeadNext = rxShift;
            else                                    rxHeadNext = rxMem[rxRdPtrNext];
        end
    end

    always_ff @(posedge iClk) begin
        if (rxPush) rxMem[rxWrPtr] <= rxShift;
    end

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            rxState   <= RX_IDLE;
            rxTimer   <= '0;
            rxBit     <= '0;
            rxShift   <= '0;
            rxParErr  <= 1'b0;
            rxWrPtr   <= '0;
            rxRdPtr   <= '0;
            oRxCount  <= '0;
            oRxEmpty  <= 1'b1;
            oRxData   <= '0;
            oErrFlags <= '0;
        end else begin
            rxState   <= rxStateNext;
            rxTimer   <= rxTimerNext;
            rxBit     <= rxBitNext;
            rxShift   <= rxShiftNext;
            rxParErr  <= rxParErrNext;
            rxWrPtr   <= rxWrPtr + RAW'(rxPush);
            rxRdPtr   <= rxRdPtrNext;
            oRxCount  <= rxCountNext;
            oRxEmpty  <= (rxCountNext == '0);
            oRxData   <= rxHeadNext;
            oErrFlags <= (oErrFlags & ~{3{iErrClear}}) | {setOvr, setPar, setFrm};
        end
    end

endmodule

// File: tb/tb_uart_fifo_cfg.sv
// Directed bench for uart_fifo_cfg: instance A at default parameters, instance B with
// even parity, two stop bits, 16-cycle bits and depth-4 FIFOs.
module tb_uart_fifo_cfg;

    localparam int BIT_A = 416;
    localparam int BIT_B = 16;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    // Instance A signals
    logic       rxA, rxReadA, txWriteA, errClearA;
    logic [7:0] txDataA;
    logic       oTxA, rxEmptyA, txFullA, txBusyA;
    logic [7:0] rxDataA;
    logic [4:0] rxCountA, txCountA;
    logic [2:0] errA;

    // Instance B signals
    logic       rxB, rxReadB, txWriteB, errClearB;
    logic [7:0] txDataB;
    logic       oTxB, rxEmptyB, txFullB, txBusyB;
    logic [7:0] rxDataB;
    logic [2:0] rxCountB, txCountB;
    logic [2:0] errB;

    int checks = 0;
    int errors = 0;

    logic [7:0] ovrBytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    uart_fifo_cfg uA (
        .iClk(clk), .iResetn(rstN), .iRx(rxA),
`ifdef UART_LOOPBACK_EN
        .iLoopback(1'b0),
`endif
        .oTx(oTxA), .oRxData(rxDataA), .iRxRead(rxReadA), .oRxEmpty(rxEmptyA),
        .oRxCount(rxCountA), .iTxData(txDataA), .iTxWrite(txWriteA), .oTxFull(txFullA),
        .oTxCount(txCountA), .oTxBusy(txBusyA), .oErrFlags(errA), .iErrClear(errClearA)
    );

    uart_fifo_cfg #(
        .pClkFreq(1_600_000), .pBaudRate(100_000), .pDataBits(8), .pParity(2),
        .pStopBits(2), .pRxFifoDepth(4), .pTxFifoDepth(4)
    ) uB (
        .iClk(clk), .iResetn(rstN), .iRx(rxB),
`ifdef UART_LOOPBACK_EN
        .iLoopback(1'b0),
`endif
        .oTx(oTxB), .oRxData(rxDataB), .iRxRead(rxReadB), .oRxEmpty(rxEmptyB),
        .oRxCount(rxCountB), .iTxData(txDataB), .iTxWrite(txWriteB), .oTxFull(txFullB),
        .oTxCount(txCountB), .oTxBusy(txBusyB), .oErrFlags(errB), .iErrClear(errClearB)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setRx(input int sel, input logic v);
        if (sel == 0) rxA = v;
        else          rxB = v;
    endtask

    function automatic logic getTx(input int sel);
        return (sel == 0) ? oTxA : oTxB;
    endfunction

    function automatic logic getTxBusy(input int sel);
        return (sel == 0) ? txBusyA : txBusyB;
    endfunction

    function automatic logic [31:0] getTxCount(input int sel);
        return (sel == 0) ? 32'(txCountA) : 32'(txCountB);
    endfunction

    // Drive one serial frame; a zero stop bit leaves the line low afterwards.
    task automatic sendFrame(input int sel, input logic [7:0] d, input int bitCyc,
                             input int hasPar, input logic parBit, input logic stopBit);
        setRx(sel, 1'b0);
        waitCyc(bitCyc);
        for (int i = 0; i < 8; i++) begin
            setRx(sel, d[i]);
            waitCyc(bitCyc);
        end
        if (hasPar != 0) begin
            setRx(sel, parBit);
            waitCyc(bitCyc);
        end
        setRx(sel, stopBit);
        waitCyc(bitCyc);
    endtask

    task automatic popRx(input int sel);
        if (sel == 0) rxReadA = 1'b1;
        else          rxReadB = 1'b1;
        waitCyc(1);
        rxReadA = 1'b0;
        rxReadB = 1'b0;
        waitCyc(2);
    endtask

    task automatic clearErr(input int sel);
        if (sel == 0) errClearA = 1'b1;
        else          errClearB = 1'b1;
        waitCyc(1);
        errClearA = 1'b0;
        errClearB = 1'b0;
        waitCyc(1);
    endtask

    // Queue one byte and check every transmitted bit at mid-bit plus the busy duration.
    task automatic checkTx(input int sel, input logic [7:0] d, input int bitCyc,
                           input int hasPar, input logic parBit, input int stops);
        int n;
        int el;
        int total;
        if (sel == 0) begin txDataA = d; txWriteA = 1'b1; end
        else          begin txDataB = d; txWriteB = 1'b1; end
        waitCyc(1);
        txWriteA = 1'b0;
        txWriteB = 1'b0;
        check("txCountAfterWrite", getTxCount(sel), 32'd1);
        check("txBusyAfterWrite", 32'(getTxBusy(sel)), 32'd1);
        n = 0;
        while (getTx(sel) !== 1'b0 && n < 8) begin
            waitCyc(1);
            n++;
        end
        check("txStartLatency", 32'(n), 32'd1);
        check("txCountAfterPop", getTxCount(sel), 32'd0);
        waitCyc(bitCyc / 2);
        el = bitCyc / 2;
        check("txStartBit", 32'(getTx(sel)), 32'd0);
        for (int i = 0; i < 8; i++) begin
            waitCyc(bitCyc);
            el += bitCyc;
            check("txDataBit", 32'(getTx(sel)), 32'(d[i]));
        end
        if (hasPar != 0) begin
            waitCyc(bitCyc);
            el += bitCyc;
            check("txParityBit", 32'(getTx(sel)), 32'(parBit));
        end
        for (int s = 0; s < stops; s++) begin
            waitCyc(bitCyc);
            el += bitCyc;
            check("txStopBit", 32'(getTx(sel)), 32'd1);
        end
        total = bitCyc * (9 + hasPar + stops);
        while (getTxBusy(sel) === 1'b1 && el < total + 50) begin
            waitCyc(1);
            el++;
        end
        check("txBusyDuration", 32'(el), 32'(total));
        check("txIdleHigh", 32'(getTx(sel)), 32'd1);
    endtask

    initial begin
        rstN = 1'b0;
        rxA = 1'b1; rxReadA = 1'b0; txWriteA = 1'b0; errClearA = 1'b0; txDataA = '0;
        rxB = 1'b1; rxReadB = 1'b0; txWriteB = 1'b0; errClearB = 1'b0; txDataB = '0;
        waitCyc(3);

        // Reset state
        check("rstTxA", 32'(oTxA), 32'd1);
        check("rstRxEmptyA", 32'(rxEmptyA), 32'd1);
        check("rstRxCountA", 32'(rxCountA), 32'd0);
        check("rstTxCountA", 32'(txCountA), 32'd0);
        check("rstTxFullA", 32'(txFullA), 32'd0);
        check("rstTxBusyA", 32'(txBusyA), 32'd0);
        check("rstErrA", 32'(errA), 32'd0);
        check("rstRxDataA", 32'(rxDataA), 32'd0);
        check("rstTxB", 32'(oTxB), 32'd1);
        check("rstTxFullB", 32'(txFullB), 32'd0);
        check("rstRxEmptyB", 32'(rxEmptyB), 32'd1);
        rstN = 1'b1;
        waitCyc(3);

        // TX frames: 0xA5 on A (no parity, 1 stop); 0x07 on B (even parity bit 1, 2 stops)
        checkTx(0, 8'hA5, BIT_A, 0, 1'b0, 1);
        checkTx(1, 8'h07, BIT_B, 1, 1'b1, 2);

        // RX back-to-back frames on A
        sendFrame(0, 8'h3C, BIT_A, 0, 1'b0, 1'b1);
        sendFrame(0, 8'h81, BIT_A, 0, 1'b0, 1'b1);
        waitCyc(4);
        check("rxCount2", 32'(rxCountA), 32'd2);
        check("rxHead3C", 32'(rxDataA), 32'h3C);
        check("rxNotEmpty", 32'(rxEmptyA), 32'd0);
        popRx(0);
        check("rxHead81", 32'(rxDataA), 32'h81);
        check("rxCount1", 32'(rxCountA), 32'd1);
        popRx(0);
        check("rxEmptyAfterPops", 32'(rxEmptyA), 32'd1);
        check("rxCount0", 32'(rxCountA), 32'd0);
        popRx(0);
        check("rxPopEmptyIgnored", 32'(rxCountA), 32'd0);
        check("rxNoErrA", 32'(errA), 32'd0);

        // Parity on B: good 0x96 (bit 0), then 0x07 with wrong bit 0
        sendFrame(1, 8'h96, BIT_B, 1, 1'b0, 1'b1);
        waitCyc(4);
        check("parGoodCount", 32'(rxCountB), 32'd1);
        check("parGoodNoErr", 32'(errB), 32'd0);
        sendFrame(1, 8'h07, BIT_B, 1, 1'b0, 1'b1);
        waitCyc(4);
        check("parBadCount", 32'(rxCountB), 32'd2);
        check("parBadFlag", 32'(errB), 32'b010);
        check("parHead96", 32'(rxDataB), 32'h96);
        clearErr(1);
        check("parCleared", 32'(errB), 32'b000);
        popRx(1);
        check("parHead07", 32'(rxDataB), 32'h07);
        popRx(1);
        check("parEmpty", 32'(rxEmptyB), 32'd1);

        // Overrun on B: five frames into a four-entry FIFO
        for (int i = 0; i < 5; i++) begin
            sendFrame(1, ovrBytes[i], BIT_B, 1, ^ovrBytes[i], 1'b1);
            waitCyc(4);
            if (i == 3) begin
                check("ovrFullCount", 32'(rxCountB), 32'd4);
                check("ovrNoErrYet", 32'(errB), 32'd0);
            end
        end
        check("ovrCountHeld", 32'(rxCountB), 32'd4);
        check("ovrFlag", 32'(errB), 32'b100);
        for (int i = 0; i < 4; i++) begin
            check("ovrKeptData", 32'(rxDataB), 32'(ovrBytes[i]));
            popRx(1);
        end
        check("ovrDrained", 32'(rxEmptyB), 32'd1);
        clearErr(1);
        check("ovrCleared", 32'(errB), 32'd0);

        // Framing error on A: 0x55 with stop 0, line held low, then recovery
        sendFrame(0, 8'h55, BIT_A, 0, 1'b0, 1'b0);
        waitCyc(4);
        check("frmNoPush", 32'(rxCountA), 32'd0);
        check("frmFlag", 32'(errA), 32'b001);
        waitCyc(2 * BIT_A);
        check("frmBreakNoPush", 32'(rxCountA), 32'd0);
        setRx(0, 1'b1);
        waitCyc(20);
        sendFrame(0, 8'h5A, BIT_A, 0, 1'b0, 1'b1);
        waitCyc(4);
        check("frmRecoverCount", 32'(rxCountA), 32'd1);
        check("frmRecoverData", 32'(rxDataA), 32'h5A);
        check("frmSticky", 32'(errA), 32'b001);
        clearErr(0);
        check("frmCleared", 32'(errA), 32'd0);
        popRx(0);

        // 200-cycle glitch on A is rejected
        setRx(0, 1'b0);
        waitCyc(200);
        setRx(0, 1'b1);
        waitCyc(1000);
        check("glitchNoPush", 32'(rxCountA), 32'd0);
        check("glitchNoErr", 32'(errA), 32'd0);

        // Fill the TX FIFO on A with 17 writes; the engine pops the first one
        for (int i = 0; i < 17; i++) begin
            txDataA = 8'(i + 1);
            txWriteA = 1'b1;
            waitCyc(1);
        end
        txWriteA = 1'b0;
        check("txFillFull", 32'(txFullA), 32'd1);
        check("txFillCount", 32'(txCountA), 32'd16);
        txDataA = 8'hEE;
        txWriteA = 1'b1;
        waitCyc(1);
        txWriteA = 1'b0;
        check("txFullDrop", 32'(txCountA), 32'd16);
        waitCyc(20);
        check("txMidStart", 32'(oTxA), 32'd0);

        // Reset mid-frame takes effect without a clock edge
        rstN = 1'b0;
        #1;
        check("midRstTx", 32'(oTxA), 32'd1);
        check("midRstTxCount", 32'(txCountA), 32'd0);
        check("midRstTxFull", 32'(txFullA), 32'd0);
        check("midRstBusy", 32'(txBusyA), 32'd0);
        check("midRstRxCount", 32'(rxCountA), 32'd0);
        waitCyc(2);
        rstN = 1'b1;
        waitCyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_fifo_cfg.md
Name: uart_fifo_cfg

Overview:
Parametrised next-generation buffered UART. Full-duplex TX/RX engines with configurable data bits, parity mode and stop bits. Each direction has a show-ahead FIFO of configurable depth, exposes fill-level counts, and reports sticky framing, parity and overrun error flags. Sits between the board serial pins and the command/measurement logic, on the single system clock.

Parameters:
pClkFreq, 48_000_000, system clock in Hz
pBaudRate, 115200, line rate; bit period BIT = pClkFreq/pBaudRate (integer floor), 416 at defaults
pDataBits, 8, data bits per frame, legal 5..9
pParity, 0, 0 = none, 1 = odd, 2 = even
pStopBits, 1, stop bits transmitted, 1 or 2; RX always checks only the first
pRxFifoDepth, 16, RX FIFO entries, power of 2, >= 2
pTxFifoDepth, 16, TX FIFO entries, power of 2, >= 2

Ports:
iClk  in  1  system clock, all logic rising edge
iResetn  in  1  asynchronous active-low reset
iRx  in  1  serial input, asynchronous to iClk
oTx  out  1  serial output, idle high
oRxData  out  pDataBits  head of RX FIFO, valid when oRxEmpty=0
iRxRead  in  1  pop RX FIFO head on this edge
oRxEmpty  out  1  RX FIFO empty
oRxCount  out  clog2(pRxFifoDepth)+1  RX FIFO occupancy
iTxData  in  pDataBits  byte to queue
iTxWrite  in  1  push iTxData on this edge
oTxFull  out  1  TX FIFO full
oTxCount  out  clog2(pTxFifoDepth)+1  TX FIFO occupancy
oTxBusy  out  1  TX FIFO non-empty or TX engine not idle
oErrFlags  out  3  sticky errors {overrun, parity, framing}
iErrClear  in  1  clears all of oErrFlags

Behaviour:
- Reset (async assert, sync release): oTx=1, both FIFOs empty, counts=0, oRxEmpty=1, oTxFull=0, oTxBusy=0, oErrFlags=0, oRxData=0, both engines IDLE.
- FIFOs: show-ahead; pointers wrap modulo depth; count is write count minus read count.
  - Write to a full FIFO is dropped, even if a pop occurs on the same edge.
  - Read of an empty FIFO is ignored.
  - Simultaneous read+write when neither full nor empty: both take effect, count unchanged.
  - oRxData updates on the edge following a pop.
- TX engine: states IDLE, START, DATA, PARITY, STOP.
  - IDLE with FIFO non-empty: pop the head and latch it; START drives oTx=0 on the next edge.
  - Each state holds for BIT cycles. Data is sent LSB first.
  - PARITY is present only if pParity!=0: odd makes total ones odd, even makes total ones even.
  - STOP lasts pStopBits*BIT cycles at 1, then returns to IDLE. Back-to-back frames have no extra idle.
- RX engine: iRx passes through a 2-FF synchroniser; all sampling uses the synchronised value. States IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: a falling edge enters START.
  - START: at BIT/2 re-sample. If 1 it is a glitch: return to IDLE, no flags.
  - DATA/PARITY/STOP: sample at mid-bit, i.e. every BIT cycles from the start mid-point.
  - STOP sample 1: push the word, with overrun check; set parity flag if pParity!=0 and parity mismatched (word still pushed); go to IDLE immediately.
  - STOP sample 0: word discarded, framing flag set, enter BREAK. BREAK goes to IDLE when iRx is 1.
  - Overrun: FIFO full at push time drops the new word and sets the overrun flag; FIFO contents are unchanged.
- oErrFlags: bits set and clear on the same edge: set wins.
- Reset mid-frame aborts both engines; oTx returns to 1 immediately.

Optional Feature:
UART_LOOPBACK_EN: adds input iLoopback (1 bit).
- When iLoopback=1: the RX synchroniser input is taken from the internal TX line instead of iRx, and oTx is held at 1.
- When iLoopback=0: normal operation.
- Without the macro: no iLoopback port, and RX always uses iRx.

Test Plan:
1. Defaults: write 0xA5 -> oTx low for 416 cycles, then 1,0,1,0,0,1,0,1 each 416 cycles, then high; oTxBusy falls 4160 cycles after start.
2. Drive iRx frames 0x3C, 0x81 back-to-back -> oRxCount=2, oRxData=0x3C; after iRxRead, oRxData=0x81, then oRxEmpty=1.
3. pParity=2: send 0x07 with a wrong parity bit -> 0x07 in FIFO, oErrFlags=3'b010; iErrClear -> 3'b000.
4. Frame 0x55 with stop bit 0 -> no push, oErrFlags=3'b001, no further RX until iRx is high again.
5. RX depth 4: send 5 bytes without reading -> oRxCount=4, the first 4 bytes retained, oErrFlags[2]=1. 200-cycle iRx low glitch -> nothing received.
6. Write 17 bytes into TX depth 16 in consecutive cycles -> oTxFull asserts. The 17th byte is dropped only if the engine has not yet popped. Asserting iResetn=0 mid-frame -> oTx=1 and all counts 0 immediately.
